uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed character (`rx_data` plus `parity_error`) on the rising edge of the receiver's `rx_done`, acknowledges it back through `host_read_data`, and stores it in a first-word-fall-through FIFO. The FIFO is drained by the APB register block. The block also generates hysteretic `rts_n` flow control and a sticky overrun flag.

## Interface
- `DEPTH`, 16: number of entries; power of 2, minimum 4.
- `RTS_HIGH`, DEPTH-2: `rts_n` goes high when `count` >= this value.
- `RTS_LOW`, DEPTH/2: `rts_n` goes low when `count` <= this value; must be < `RTS_HIGH`.
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: character from the receiver.
- `rx_parity_err` in 1: parity error for that character.
- `rx_done` in 1: receiver character-complete level; may stay high for many cycles.
- `host_read_data` out 1: one-cycle acknowledge to the receiver.
- `rd_en` in 1: pop request from the APB side.
- `rd_data` out 8: head entry data.
- `rd_parity_err` out 1: head entry parity flag.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overrun` out 1: sticky; a character was dropped.
- `overrun_clr` in 1: clears `overrun`.
- `flush` in 1: synchronous clear of the FIFO contents.
- `rts_n` out 1: flow control to the peer; 1 = stop sending.

## Operation
- Push event:
  - `rx_done_q` is a registered copy of `rx_done`; a push event is `rx_done & ~rx_done_q`.
  - A level held high produces exactly one push.
- Entry format: 9 bits, {`rx_parity_err`, `rx_data`}, sampled in the push-event cycle.
- Push when not full (or when full with a simultaneous valid pop):
  - write the entry at `wr_ptr`;
  - `wr_ptr` increments modulo DEPTH.
- Push when full with no pop: the entry is dropped and `overrun` is set to 1. Nothing else changes.
- Pop:
  - `rd_en & ~empty` advances `rd_ptr` modulo DEPTH.
  - `rd_en` while empty is ignored and has no side effects.
- Output data: `rd_data`/`rd_parity_err` reflect `mem[rd_ptr]` combinationally while `!empty`, and are 0 when empty.
- Count:
  - `count` +1 on push only, -1 on pop only, unchanged on push+pop.
  - `empty` = (`count`==0); `full` = (`count`==DEPTH).
- Acknowledge: `host_read_data` is 1 for exactly one cycle, in the cycle after every push event, whether the entry was stored or dropped.
- Overrun flag: `overrun` is set on a drop and cleared on `overrun_clr`. If both happen in the same cycle, set wins.
- Flush:
  - `flush` zeroes the pointers, `count` and `overrun`, and forces `rts_n` to 0.
  - It has priority over push and pop in the same cycle; that push is discarded without setting `overrun`, but is still acknowledged.
- Flow control (`rts_n`, registered, evaluated on the next-state count):
  - set to 1 when count_next >= `RTS_HIGH`;
  - cleared to 0 when count_next <= `RTS_LOW`;
  - otherwise held.
- No state machine beyond the `rts_n` hysteresis bit.

## Timing
- Reset values: `host_read_data`=0, `rd_data`=0, `rd_parity_err`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0, `rts_n`=0. `rx_done_q` resets to 0, so `rx_done` high at reset release produces a push.
- Push latency (cycle N = push event):
  - `count`, `empty`, `full`, `rd_data` and `rts_n` update at N+1;
  - `host_read_data` is high during N+1.
- Pop latency: `rd_data` shows the next entry and `count` decrements in the cycle after the `rd_en` cycle.
- Simultaneous push+pop:
  - when full, both take effect and `overrun` is not set;
  - when empty, the push takes effect and the pop is ignored.
- Pointer wrap: pointers wrap DEPTH-1 → 0 with no bubble.
- Reset mid-operation: all state clears asynchronously; memory contents need not be cleared.

## Test plan
- Reset, then three push events (0x41, 0x42 with parity_err=1, 0x43):
  - `count`=3 and `host_read_data` pulses three times;
  - pops return 0x41/0, 0x42/1, 0x43/0, then `empty`=1.
- Hold `rx_done` high for 50 cycles → exactly one entry, one `host_read_data` pulse.
- DEPTH=16: push 0x00..0x0F (`full`=1), then push 0xAA:
  - `overrun`=1, `count`=16, head still 0x00;
  - `overrun_clr` → `overrun`=0.
- Full FIFO, push 0x55 and pop in the same cycle:
  - 0x00 is consumed, `count` stays 16, `overrun`=0;
  - after 15 more pops, the head is 0x55.
- `rts_n` hysteresis (defaults):
  - rises in the cycle after `count` reaches 14;
  - stays 1 while draining to 9;
  - falls when `count` reaches 8.
- Push 5 entries, assert `flush` together with a push event:
  - `count`=0, `empty`=1, `overrun`=0, `rts_n`=0;
  - `host_read_data` still pulses;
  - assert `reset_n`=0 mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected capture into a
// first-word-fall-through FIFO, with hysteretic rts_n and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int RTS_HIGH = DEPTH - 2,
    parameter int RTS_LOW  = DEPTH / 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_parity_err,
    input  logic                     rx_done,
    output logic                     host_read_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     overrun_clr,
    input  logic                     flush,
    output logic                     rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] RTS_HIGH_C = CW'(RTS_HIGH);
    localparam logic [CW-1:0] RTS_LOW_C  = CW'(RTS_LOW);

    logic [8:0]    mem [DEPTH];
    logic [8:0]    head;
    logic          rx_done_q, rx_done_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          rts_q, rts_d;
    logic          push_evt, push_ok, pop, mem_we;
    logic          empty_w, full_w;

    // Handshakes: a rising edge of rx_done is one character, acknowledged by a
    // single-cycle host_read_data pulse; rd_en pops only while the FIFO is non-empty.
    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == DEPTH_C);
    assign push_evt = rx_done & ~rx_done_q;
    assign pop      = rd_en & ~empty_w;

    always_comb begin
        rx_done_d = rx_done;
        ack_d     = push_evt;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        push_ok   = 1'b0;
        mem_we    = 1'b0;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (overrun_clr)
                overrun_d = 1'b0;
            // A pop in the same cycle frees the slot this push would need.
            if (push_evt) begin
                if (!full_w || pop) begin
                    push_ok  = 1'b1;
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else begin
                    overrun_d = 1'b1;
                end
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
        end

        rts_d = rts_q;
        if (count_d >= RTS_HIGH_C)
            rts_d = 1'b1;
        else if (count_d <= RTS_LOW_C)
            rts_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q <= 1'b0;
            ack_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            rx_done_q <= rx_done_d;
            ack_q     <= ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
        end
    end

    // Storage is not reset; the empty mask hides stale contents.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr_q] <= {rx_parity_err, rx_data};
    end

    assign head           = mem[rd_ptr_q];
    assign rd_data        = empty_w ? 8'h00 : head[7:0];
    assign rd_parity_err  = empty_w ? 1'b0 : head[8];
    assign empty          = empty_w;
    assign full           = full_w;
    assign count          = count_q;
    assign overrun        = overrun_q;
    assign rts_n          = rts_q;
    assign host_read_data = ack_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random checks of uart_rx_fifo against a queue-based model of
// the receive buffer, flow control, overrun and flush rules.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_parity_err = 1'b0;
    logic       rx_done = 1'b0;
    logic       host_read_data;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    logic       flush = 1'b0;
    logic       rts_n;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;
    int a0;

    logic [8:0] exp_q[$];
    bit m_ovr = 1'b0;
    bit m_rts = 1'b0;
    bit m_prev = 1'b0;
    bit m_ack = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_done(rx_done), .host_read_data(host_read_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_parity_err(rd_parity_err), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .overrun_clr(overrun_clr), .flush(flush),
        .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: queue holds stored characters; pop is applied before the push
    // so a full FIFO with a pop has room for the incoming character.
    task automatic model_step();
        bit pe;
        bit p;
        if (!reset_n) begin
            exp_q.delete();
            m_ovr = 1'b0; m_rts = 1'b0; m_prev = 1'b0; m_ack = 1'b0;
            return;
        end
        pe = rx_done && !m_prev;
        m_prev = rx_done;
        m_ack = pe;
        if (flush) begin
            exp_q.delete();
            m_ovr = 1'b0;
        end else begin
            p = rd_en && (exp_q.size() > 0);
            if (p) void'(exp_q.pop_front());
            if (overrun_clr) m_ovr = 1'b0;
            if (pe) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({rx_parity_err, rx_data});
                else m_ovr = 1'b1;
            end
        end
        if (exp_q.size() >= DEPTH - 2) m_rts = 1'b1;
        else if (exp_q.size() <= DEPTH / 2) m_rts = 1'b0;
    endtask

    task automatic check_all();
        logic [8:0] exp_head;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : 9'h000;
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("empty", 32'(empty), 32'(exp_q.size() == 0));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("rd_data", 32'(rd_data), 32'(exp_head[7:0]));
        chk("rd_parity_err", 32'(rd_parity_err), 32'(exp_head[8]));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("rts_n", 32'(rts_n), 32'(m_rts));
        chk("host_read_data", 32'(host_read_data), 32'(m_ack));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (host_read_data) ack_seen++;
        check_all();
    endtask

    task automatic push_char(input logic [7:0] d, input logic pe);
        rx_data = d; rx_parity_err = pe; rx_done = 1'b1;
        cycle();
        rx_done = 1'b0;
        cycle();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rts", 32'(rts_n), 32'd0);
        reset_n = 1'b1;
        cycle();

        // Three characters in, three out
        a0 = ack_seen;
        push_char(8'h41, 1'b0);
        push_char(8'h42, 1'b1);
        push_char(8'h43, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_acks", 32'(ack_seen - a0), 32'd3);
        chk("t1_head0", 32'({rd_parity_err, rd_data}), 32'h041);
        pop_one();
        chk("t1_head1", 32'({rd_parity_err, rd_data}), 32'h142);
        pop_one();
        chk("t1_head2", 32'({rd_parity_err, rd_data}), 32'h043);
        pop_one();
        chk("t1_empty", 32'(empty), 32'd1);

        // Level held high yields one push
        a0 = ack_seen;
        rx_data = 8'h77; rx_done = 1'b1;
        repeat (50) cycle();
        rx_done = 1'b0;
        cycle();
        chk("hold_count", 32'(count), 32'd1);
        chk("hold_acks", 32'(ack_seen - a0), 32'd1);
        pop_one();

        // Fill, then overrun
        for (int i = 0; i < DEPTH; i++) push_char(8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        push_char(8'hAA, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_count", 32'(count), 32'd16);
        chk("ovr_head", 32'({rd_parity_err, rd_data}), 32'h000);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Push and pop together on a full FIFO
        rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        cycle();
        rx_done = 1'b0; rd_en = 1'b0;
        cycle();
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovr", 32'(overrun), 32'd0);
        chk("pp_head", 32'({rd_parity_err, rd_data}), 32'h001);
        repeat (15) pop_one();
        chk("pp_tail", 32'({rd_parity_err, rd_data}), 32'h055);
        pop_one();
        chk("pp_empty", 32'(empty), 32'd1);

        // rts_n hysteresis
        for (int i = 0; i < 13; i++) push_char(8'($urandom), 1'b0);
        chk("rts_13", 32'(rts_n), 32'd0);
        push_char(8'($urandom), 1'b0);
        chk("rts_14", 32'(rts_n), 32'd1);
        repeat (5) pop_one();
        chk("rts_9", 32'(rts_n), 32'd1);
        pop_one();
        chk("rts_8", 32'(rts_n), 32'd0);
        repeat (8) pop_one();

        // Flush with a simultaneous push, from a full FIFO with overrun set
        for (int i = 0; i < 5; i++) push_char(8'($urandom), 1'($urandom));
        chk("fl_count5", 32'(count), 32'd5);
        for (int i = 0; i < 12; i++) push_char(8'($urandom), 1'b0);
        chk("fl_ovr_pre", 32'(overrun), 32'd1);
        rx_data = 8'h3C; rx_done = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; rx_done = 1'b0;
        chk("fl_ack", 32'(host_read_data), 32'd1);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_ovr", 32'(overrun), 32'd0);
        chk("fl_rts", 32'(rts_n), 32'd0);
        cycle();

        // Random traffic: fill-biased phase, then drain-biased phase
        for (int i = 0; i < 500; i++) begin
            rx_done = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            rx_parity_err = 1'($urandom_range(0, 1));
            rd_en = (i < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rx_done = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0; flush = 1'b0;
        cycle();

        // Asynchronous reset mid-stream
        push_char(8'h11, 1'b1);
        push_char(8'h22, 1'b0);
        rx_data = 8'h33; rx_done = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_rd_data", 32'({rd_parity_err, rd_data}), 32'd0);
        chk("ar_ovr", 32'(overrun), 32'd0);
        chk("ar_rts", 32'(rts_n), 32'd0);
        chk("ar_ack", 32'(host_read_data), 32'd0);
        rx_done = 1'b0;
        cycle();
        rx_data = 8'h99; rx_done = 1'b1; reset_n = 1'b1;
        cycle();
        chk("rel_ack", 32'(host_read_data), 32'd1);
        chk("rel_head", 32'({rd_parity_err, rd_data}), 32'h099);
        rx_done = 1'b0;
        cycle();
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
